bcd_counter_n: RTL

Parametrised N-digit BCD up/down counter with prescaler, parallel load and wrap/borrow signalling. It generalises the fixed 4-digit display counter: it feeds the 7-segment digit multiplexer and serves as the echo-time accumulator in the ultrasound distance path. All outputs are registered or decoded directly from registers in the `clk` domain.

---
 rtl/bcd_counter_n.sv | 115 +++++++++++
 1 files changed

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with prescaler, parallel load and wrap/borrow pulse.
// Define BCD_COUNTER_SAT_EN for saturating mode; the default build wraps.
module bcd_counter_n #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  tick,
  output logic                  carry,
  output logic                  zero,
  output logic                  max
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       ps_reg, ps_next;
  logic [4*DIGITS-1:0] digits_reg, digits_next;
  logic                tick_reg, tick_next;
  logic                carry_reg, carry_next;

  logic [4*DIGITS-1:0] inc_val, dec_val, load_clamped;
  // nines_chain[i]: all digits below i are 9; zeros_chain[i]: all digits below i are 0
  logic [DIGITS:0]     nines_chain, zeros_chain;
  logic                all_nines, all_zeros;

  assign nines_chain[0] = 1'b1;
  assign zeros_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic [3:0] lv;
      assign d  = digits_reg[4*gi +: 4];
      assign lv = load_val[4*gi +: 4];

      assign nines_chain[gi+1] = nines_chain[gi] & (d == 4'd9);
      assign zeros_chain[gi+1] = zeros_chain[gi] & (d == 4'd0);

      assign inc_val[4*gi +: 4] = !nines_chain[gi] ? d :
                                  (d == 4'd9) ? 4'd0 : d + 4'd1;
      assign dec_val[4*gi +: 4] = !zeros_chain[gi] ? d :
                                  (d == 4'd0) ? 4'd9 : d - 4'd1;
      assign load_clamped[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end
  endgenerate

  assign all_nines = nines_chain[DIGITS];
  assign all_zeros = zeros_chain[DIGITS];

  always_comb begin
    ps_next     = ps_reg;
    digits_next = digits_reg;
    tick_next   = 1'b0;
    carry_next  = 1'b0;
    if (clear) begin
      ps_next     = '0;
      digits_next = '0;
    end else if (load) begin
      ps_next     = '0;
      digits_next = load_clamped;
    end else if (en) begin
      if (ps_reg == PS_LAST) begin
        ps_next   = '0;
        tick_next = 1'b1;
        if (up) begin
          carry_next = all_nines;
`ifdef BCD_COUNTER_SAT_EN
          if (!all_nines) digits_next = inc_val;
`else
          digits_next = inc_val;
`endif
        end else begin
          carry_next = all_zeros;
`ifdef BCD_COUNTER_SAT_EN
          if (!all_zeros) digits_next = dec_val;
`else
          digits_next = dec_val;
`endif
        end
      end else begin
        ps_next = ps_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_reg     <= '0;
      digits_reg <= '0;
      tick_reg   <= 1'b0;
      carry_reg  <= 1'b0;
    end else begin
      ps_reg     <= ps_next;
      digits_reg <= digits_next;
      tick_reg   <= tick_next;
      carry_reg  <= carry_next;
    end
  end

  assign digits = digits_reg;
  assign tick   = tick_reg;
  assign carry  = carry_reg;
  assign zero   = all_zeros;
  assign max    = all_nines;

endmodule
